// File: rtl/mem_pkg.sv
// Shared definitions for the load/store engine: memory opcodes, FSM state
// encoding, lane widths and an opcode decoder.
package mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LOAD_WAIT,
        ST_DONE,
        ST_ERR
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    typedef struct packed {
        logic  valid;
        logic  is_store;
        logic  is_signed;
        size_e size;
    } op_info_t;

    // Map a MIPS opcode to access attributes; non-memory opcodes come back invalid.
    function automatic op_info_t decode_op(input logic [5:0] op);
        op_info_t info;
        info = '0;
        info.valid = 1'b1;
        case (op)
            OP_LB:  begin info.is_signed = 1'b1; info.size = SZ_BYTE; end
            OP_LH:  begin info.is_signed = 1'b1; info.size = SZ_HALF; end
            OP_LW:  info.size = SZ_WORD;
            OP_LBU: info.size = SZ_BYTE;
            OP_LHU: info.size = SZ_HALF;
            OP_SB:  begin info.is_store = 1'b1; info.size = SZ_BYTE; end
            OP_SH:  begin info.is_store = 1'b1; info.size = SZ_HALF; end
            OP_SW:  begin info.is_store = 1'b1; info.size = SZ_WORD; end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Picks the addressed byte/half-word out of a RAM read word and extends it to 32 bits.
module load_extract
    import mem_pkg::*;
(
    input  logic [31:0] ram_rdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] result
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    // Lane select (little-endian) followed by sign or zero extension.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        byte_v = ram_rdata[{off, 3'b000} +: BYTE_W];
        half_v = off[1] ? ram_rdata[WORD_W-1:HALF_W] : ram_rdata[HALF_W-1:0];
        result = ram_rdata;
        case (size)
            SZ_BYTE: result = {{(WORD_W-BYTE_W){is_signed & byte_v[BYTE_W-1]}}, byte_v};
            SZ_HALF: result = {{(WORD_W-HALF_W){is_signed & half_v[HALF_W-1]}}, half_v};
            default: result = ram_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store engine between execute stage and a one-cycle-latency byte-enabled data RAM.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req,
    input  logic [5:0]            opcode,
    input  logic [31:0]           address,
    input  logic [31:0]           store_data,
    output logic [31:0]           mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_err,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata
);

    state_e                state_q, state_d;
    op_info_t              op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  ram_en_q, ram_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [3:0]            ram_we_q, ram_we_d;
    logic [31:0]           ram_wdata_q, ram_wdata_d;

    op_info_t    req_info;
    logic        req_bad;
    logic [31:0] load_value;

    load_extract u_load_extract (
        .ram_rdata (ram_rdata),
        .off       (off_q),
        .size      (op_q.size),
        .is_signed (op_q.is_signed),
        .result    (load_value)
    );

    // Decode the incoming request and flag misaligned or out-of-range addresses.
    always_comb begin
        req_info = decode_op(opcode);
        req_bad  = ((address >> (ADDR_WIDTH + 2)) != 32'd0);
        case (req_info.size)
            SZ_HALF: req_bad = req_bad | address[0];
            SZ_WORD: req_bad = req_bad | (address[1:0] != 2'b00);
            default: ;
        endcase
    end

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        mem_data_d  = mem_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        ram_en_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_we_d    = 4'b0000;
        ram_wdata_d = ram_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req && req_info.valid) begin
                    op_d  = req_info;
                    off_d = address[1:0];
                    if (req_bad) begin
                        state_d = ST_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d    = ST_ACCESS;
                        ram_en_d   = 1'b1;
                        ram_addr_d = address[ADDR_WIDTH+1:2];
                        if (req_info.is_store) begin
                            case (req_info.size)
                                SZ_BYTE: begin
                                    ram_we_d    = 4'b0001 << address[1:0];
                                    ram_wdata_d = {4{store_data[BYTE_W-1:0]}};
                                end
                                SZ_HALF: begin
                                    ram_we_d    = address[1] ? 4'b1100 : 4'b0011;
                                    ram_wdata_d = {2{store_data[HALF_W-1:0]}};
                                end
                                default: begin
                                    ram_we_d    = 4'b1111;
                                    ram_wdata_d = store_data;
                                end
                            endcase
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (op_q.is_store) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_LOAD_WAIT;
                end
            end
            ST_LOAD_WAIT: begin
                mem_data_d = load_value;
                state_d    = ST_DONE;
                done_d     = 1'b1;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            off_q       <= 2'b00;
            mem_data_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 4'b0000;
            ram_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ram_en_q    <= ram_en_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign mem_data  = mem_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_err  = err_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    // The RAM samples its strobes on the same edge that applies reset, so an
    // access already in flight is squashed here to keep reset from writing.
    assign ram_en    = ram_en_q & reset;
    assign ram_we    = ram_we_q & {4{reset}};

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: byte-addressed reference memory, behavioural RAM, randomized accesses.
module tb_mem_access_unit;

    localparam logic [5:0] T_LB  = 6'b100000;
    localparam logic [5:0] T_LH  = 6'b100001;
    localparam logic [5:0] T_LW  = 6'b100011;
    localparam logic [5:0] T_LBU = 6'b100100;
    localparam logic [5:0] T_LHU = 6'b100101;
    localparam logic [5:0] T_SB  = 6'b101000;
    localparam logic [5:0] T_SH  = 6'b101001;
    localparam logic [5:0] T_SW  = 6'b101011;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [31:0] address = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic [31:0] mem_data;
    logic        busy, done, addr_err, ram_en;
    logic [13:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    bit   [31:0] ram [0:16383];
    int          ram_writes = 0;
    logic [7:0]  ref_mem [int];
    logic [31:0] model_mem_data = 32'd0;

    mem_access_unit #(.ADDR_WIDTH(14)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .opcode     (opcode),
        .address    (address),
        .store_data (store_data),
        .mem_data   (mem_data),
        .busy       (busy),
        .done       (done),
        .addr_err   (addr_err),
        .ram_en     (ram_en),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clock = ~clock;

    // Synchronous byte-enabled RAM with one-cycle read latency.
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_we != 4'b0000) begin
                for (int i = 0; i < 4; i++)
                    if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
                ram_writes <= ram_writes + 1;
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    function automatic int op_size(input logic [5:0] op);
        if (op == T_LB || op == T_LBU || op == T_SB) return 1;
        if (op == T_LH || op == T_LHU || op == T_SH) return 2;
        return 4;
    endfunction

    function automatic bit op_is_load(input logic [5:0] op);
        return (op == T_LB || op == T_LH || op == T_LW || op == T_LBU || op == T_LHU);
    endfunction

    function automatic bit op_signed(input logic [5:0] op);
        return (op == T_LB || op == T_LH);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        int k = int'(a);
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int size, input bit sgn);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < size; i++)
            v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
        if (sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input int size, input logic [31:0] d);
        for (int i = 0; i < size; i++) ref_mem[int'(a + 32'(i))] = d[8*i +: 8];
    endtask

    // One complete access from request to return to IDLE, checked cycle by cycle.
    task automatic do_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        int          size = op_size(op);
        bit          ld = op_is_load(op);
        bit          err;
        int          exp_cyc;
        int          done_cyc = 0;
        bit          en_seen = 1'b0;
        bit          err_seen = 1'b0;
        logic [3:0]  exp_we = 4'b0000;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        int          w0 = ram_writes;
        err = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00) || (addr[31:16] != 16'd0);
        exp_cyc = err ? 1 : (ld ? 3 : 2);
        for (int i = 0; i < size; i++) exp_we[(int'(addr[1:0]) + i) % 4] = 1'b1;
        exp_wd = (size == 1) ? {4{data[7:0]}} : (size == 2) ? {2{data[15:0]}} : data;
        exp_rd = ref_load(addr, size, op_signed(op));

        @(negedge clock);
        req = 1'b1; opcode = op; address = addr; store_data = data;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clock);
            if (cyc == 1) begin
                req = 1'b0;
                if (!err) begin
                    tests_run++;
                    if (ram_en !== 1'b1 || ram_addr !== addr[15:2] || ram_we !== (ld ? 4'b0000 : exp_we)) begin
                        tests_failed++;
                        $display("FAIL access_c1 op=%b addr=%h: got en=%b ra=%h we=%b expected en=1 ra=%h we=%b",
                                 op, addr, ram_en, ram_addr, ram_we, addr[15:2], ld ? 4'b0000 : exp_we);
                    end
                    if (!ld) begin
                        tests_run++;
                        if (ram_wdata !== exp_wd) begin
                            tests_failed++;
                            $display("FAIL wdata op=%b addr=%h: got %h expected %h", op, addr, ram_wdata, exp_wd);
                        end
                    end
                end
            end
            if (ram_en === 1'b1) en_seen = 1'b1;
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL busy op=%b cycle %0d: got %b expected 1", op, cyc, busy);
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                err_seen = addr_err;
                break;
            end
        end

        tests_run++;
        if (done_cyc != exp_cyc) begin
            tests_failed++;
            $display("FAIL done_latency op=%b addr=%h: got %0d expected %0d", op, addr, done_cyc, exp_cyc);
        end
        tests_run++;
        if (err_seen !== err) begin
            tests_failed++;
            $display("FAIL addr_err op=%b addr=%h: got %b expected %b", op, addr, err_seen, err);
        end
        if (err) begin
            tests_run++;
            if (en_seen) begin
                tests_failed++;
                $display("FAIL err_ram_en op=%b addr=%h: got 1 expected 0", op, addr);
            end
        end
        if (ld && !err) model_mem_data = exp_rd;
        tests_run++;
        if (mem_data !== model_mem_data) begin
            tests_failed++;
            $display("FAIL mem_data op=%b addr=%h: got %h expected %h", op, addr, mem_data, model_mem_data);
        end

        @(negedge clock);
        tests_run++;
        if (done !== 1'b0 || busy !== 1'b0 || addr_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after op=%b: got done=%b busy=%b err=%b expected 0 0 0", op, done, busy, addr_err);
        end
        if (!ld && !err) ref_store(addr, size, data);
        tests_run++;
        if (ram_writes != w0 + ((!ld && !err) ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL write_count op=%b addr=%h: got %0d expected %0d", op, addr, ram_writes - w0,
                     (!ld && !err) ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        req = 1'b1; opcode = T_SW; address = 32'h10; store_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({mem_data, busy, done, addr_err, ram_en, ram_addr, ram_we, ram_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got md=%h busy=%b done=%b err=%b en=%b ra=%h we=%b wd=%h expected all 0",
                     mem_data, busy, done, addr_err, ram_en, ram_addr, ram_we, ram_wdata);
        end
        reset = 1'b1; req = 1'b0;
        @(negedge clock);
        req = 1'b1; opcode = 6'b000000;
        begin
            bit any = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                if (done !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0) any = 1'b1;
            end
            tests_run++;
            if (any) begin
                tests_failed++;
                $display("FAIL bad_opcode_ignored: got activity=1 expected 0");
            end
        end
        req = 1'b0;
        tests_run++;
        if (ram_writes != 0) begin
            tests_failed++;
            $display("FAIL reset_no_write: got %0d writes expected 0", ram_writes);
        end
    endtask

    task automatic test_directed;
        do_access(T_SW, 32'h10, 32'hDEAD_BEEF);
        do_access(T_LW, 32'h10, 32'h0);
        tests_run++;
        if (mem_data !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL lw_deadbeef: got %h expected deadbeef", mem_data);
        end
        do_access(T_SW, 32'h20, 32'h0);
        do_access(T_SB, 32'h21, 32'h0000_0080);
        do_access(T_LB, 32'h21, 32'h0);
        tests_run++;
        if (mem_data !== 32'hFFFF_FF80) begin
            tests_failed++;
            $display("FAIL lb_sign: got %h expected ffffff80", mem_data);
        end
        do_access(T_LBU, 32'h21, 32'h0);
        tests_run++;
        if (mem_data !== 32'h0000_0080) begin
            tests_failed++;
            $display("FAIL lbu_zero: got %h expected 00000080", mem_data);
        end
        do_access(T_LHU, 32'h20, 32'h0);
        tests_run++;
        if (mem_data !== 32'h0000_8000) begin
            tests_failed++;
            $display("FAIL lhu_zero: got %h expected 00008000", mem_data);
        end
        do_access(T_SH, 32'h22, 32'h0000_C3A5);
        do_access(T_LH, 32'h22, 32'h0);
    endtask

    task automatic test_errors;
        do_access(T_LH, 32'h13, 32'h0);
        do_access(T_LW, 32'h16, 32'h0);
        do_access(T_LW, 32'h0001_0010, 32'h0);
        do_access(T_SH, 32'h11, 32'h1234_5678);
        do_access(T_SW, 32'h8000_0000, 32'h1234_5678);
    endtask

    task automatic test_busy_ignore;
        int dones = 0;
        int w0 = ram_writes;
        logic [31:0] exp = ref_load(32'h10, 4, 1'b0);
        @(negedge clock);
        req = 1'b1; opcode = T_LW; address = 32'h10;
        @(negedge clock);
        opcode = T_SW; address = 32'h10; store_data = 32'h0BAD_F00D;
        @(negedge clock);
        req = 1'b0;
        if (done === 1'b1) dones++;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (done === 1'b1) dones++;
        end
        model_mem_data = exp;
        tests_run++;
        if (dones != 1 || ram_writes != w0) begin
            tests_failed++;
            $display("FAIL busy_ignore: got dones=%0d writes=%0d expected 1 0", dones, ram_writes - w0);
        end
        tests_run++;
        if (mem_data !== exp) begin
            tests_failed++;
            $display("FAIL busy_ignore_data: got %h expected %h", mem_data, exp);
        end
    endtask

    task automatic test_reset_midflight;
        int w0 = ram_writes;
        @(negedge clock);
        req = 1'b1; opcode = T_SW; address = 32'h30; store_data = 32'h1234_5678;
        @(negedge clock);
        req = 1'b0; reset = 1'b0;
        #1;
        tests_run++;
        if (ram_we !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_cycle_we: got %b expected 0000", ram_we);
        end
        @(negedge clock);
        model_mem_data = 32'd0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || ram_we !== 4'b0000 || mem_data !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_midflight: got busy=%b done=%b we=%b md=%h expected 0 0 0000 0",
                     busy, done, ram_we, mem_data);
        end
        reset = 1'b1;
        tests_run++;
        if (ram_writes != w0) begin
            tests_failed++;
            $display("FAIL reset_midflight_write: got %0d writes expected 0", ram_writes - w0);
        end
        do_access(T_LW, 32'h30, 32'h0);
    endtask

    // Hold req high and check that completions arrive at the minimum spacing.
    task automatic run_held(input logic [5:0] op, input int spacing, input int first);
        int pos[$];
        bit gaps_ok = 1'b1;
        @(negedge clock);
        req = 1'b1; opcode = op; address = 32'h44; store_data = 32'hA5C3_0F96;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (done === 1'b1) pos.push_back(cyc);
        end
        req = 1'b0;
        for (int i = 1; i < pos.size(); i++) if (pos[i] - pos[i-1] != spacing) gaps_ok = 1'b0;
        tests_run++;
        if (pos.size() != 12 / spacing || pos.size() == 0 || pos[0] != first || !gaps_ok) begin
            tests_failed++;
            $display("FAIL back_to_back op=%b: got %0d dones first=%0d gaps_ok=%b expected %0d first=%0d gap=%0d",
                     op, pos.size(), (pos.size() > 0) ? pos[0] : -1, gaps_ok, 12 / spacing, first, spacing);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back;
        int w0 = ram_writes;
        run_held(T_SW, 3, 2);
        ref_store(32'h44, 4, 32'hA5C3_0F96);
        tests_run++;
        if (ram_writes - w0 != 4) begin
            tests_failed++;
            $display("FAIL back_to_back_writes: got %0d expected 4", ram_writes - w0);
        end
        run_held(T_LW, 4, 3);
        model_mem_data = ref_load(32'h44, 4, 1'b0);
        tests_run++;
        if (mem_data !== model_mem_data) begin
            tests_failed++;
            $display("FAIL back_to_back_load: got %h expected %h", mem_data, model_mem_data);
        end
    endtask

    task automatic test_random;
        logic [5:0] ops [8] = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW};
        for (int n = 0; n < 80; n++) begin
            logic [5:0]  op = ops[$urandom_range(0, 7)];
            logic [31:0] a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(16, 31));
            do_access(op, a, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_busy_ignore();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store engine that produces the `mem_data` word consumed by register writeback, and that performs stores into data RAM.
- Sits between the execute stage (`ALU_result` address, `read_data_2` store value, opcode) and a synchronous byte-enabled data RAM with one-cycle read latency.
- Sequences each access through a small FSM and asserts `busy` so the CPU stalls.
- Handles byte and half-word lane selection, sign and zero extension, and misaligned-address detection.

Parameters:
- `ADDR_WIDTH`, 14, word-address width of the data RAM (RAM depth = 2**ADDR_WIDTH words).

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  1  access request, sampled only in IDLE.
- `opcode`  in  6  MIPS opcode, i.e. `Instruction[31:26]`.
- `address`  in  32  byte address, taken from `ALU_result`.
- `store_data`  in  32  value to store, taken from `read_data_2`.
- `mem_data`  out  32  load result, extended to 32 bits.
- `busy`  out  1  high whenever state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `addr_err`  out  1  one-cycle pulse, coincident with `done`, on a misaligned or out-of-range access.
- `ram_en`  out  1  RAM access enable.
- `ram_addr`  out  ADDR_WIDTH  RAM word address.
- `ram_we`  out  4  byte write enables; bit i enables byte lane [8i+7:8i].
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en` with `ram_we` = 0.

Behaviour:
- Reset (`reset` == 0 at a clock edge):
  - state = IDLE.
  - `mem_data`, `ram_addr`, `ram_wdata` = 0; `busy`, `done`, `addr_err`, `ram_en` = 0; `ram_we` = 0.
  - Reset overrides any access in flight. No RAM write is issued on the reset cycle or after it.
- All outputs are registered.
- Supported opcodes:
  - lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101.
  - sb 101000, sh 101001, sw 101011.
- In IDLE, `req` = 1 with any other opcode is ignored: no state change, no `done`.
- Error check, evaluated in IDLE on an accepted request:
  - Half-word access with `address[0]` = 1, word access with `address[1:0]` != 0, or `address[31:ADDR_WIDTH+2]` != 0.
  - Result: go to ERR. No RAM enable, `mem_data` unchanged.
- States:
  - IDLE: on a valid request, latch opcode, offset and store data, then go to ACCESS (or ERR). Cycle 0 is the request cycle.
  - ACCESS (cycle 1): `ram_en` = 1, `ram_addr` = `address[ADDR_WIDTH+1:2]`.
    - Store: drive `ram_we` / `ram_wdata` (see below), go to DONE.
    - Load: `ram_we` = 0, go to LOAD_WAIT.
  - LOAD_WAIT (cycle 2): `ram_rdata` is valid. Capture the extracted value into `mem_data` at the end of the cycle; go to DONE.
  - DONE: `done` = 1 for exactly one cycle, `ram_en` = 0, then IDLE.
    - Store: DONE is cycle 2.
    - Load: DONE is cycle 3, and `mem_data` is valid from cycle 3 and held until the next load completes.
  - ERR (cycle 1): `done` = 1 and `addr_err` = 1 for one cycle, then IDLE.
- Store lane rules (little-endian, `off` = `address[1:0]`):
  - sb: `ram_we` = 4'b0001 << off; `ram_wdata` = the low byte replicated 4 times.
  - sh: `ram_we` = 4'b0011 when off[1] = 0, else 4'b1100; `ram_wdata` = the low half replicated 2 times.
  - sw: `ram_we` = 4'b1111; `ram_wdata` = `store_data`.
- Load extraction:
  - lb/lbu: byte `off`, sign- or zero-extended respectively.
  - lh/lhu: half `off[1]`, sign- or zero-extended respectively.
  - lw: the whole word.
- While `busy` = 1, `req` and input changes are ignored. Inputs are latched only in IDLE.
- Back-to-back requests: `req` held high across DONE is accepted on the IDLE cycle that follows. Minimum spacing is therefore 3 cycles per store and 4 per load.

Decomposition:
- Shared package `mem_pkg`:
  - The 8 memory opcode constants.
  - The state encoding (IDLE, ACCESS, LOAD_WAIT, DONE, ERR).
  - Lane-width constants.
- One combinational sub-module `load_extract`: inputs (`ram_rdata`, `off`, size, is_signed), output 32-bit result.

Test Plan:
- Hold `reset` low for 2 cycles, raise it → all outputs 0, `busy` = 0; `req` with opcode 000000 → no `done`.
- sw 0xDEADBEEF to address 0x10, then lw 0x10:
  - Store: `ram_we` = 1111 at cycle 1, `done` at cycle 2.
  - Load: `mem_data` = 0xDEADBEEF with `done` at cycle 3.
- sb 0x80 to 0x21 over a word of 0 at 0x20:
  - Store: `ram_we` = 0010.
  - lb 0x21 → 0xFFFFFF80; lbu 0x21 → 0x00000080; lhu 0x20 → 0x00008000.
- lh at 0x13 and lw at 0x16 → `addr_err` = `done` = 1 at cycle 1, `ram_en` never high, `mem_data` unchanged.
- Issue lw; pulse `req` again with sw at cycle 1 → second request ignored, no RAM write, exactly one `done`.
- Start sw; drive `reset` low at cycle 1 (ACCESS) → next cycle state IDLE, `ram_we` = 0, `done` = 0; RAM word unchanged.
